// File: rtl/pool2x2_stream.sv
// 2x2 / stride-2 pooling stage for a raster-ordered conv output stream.
// It supports runtime max/avg mode, optional ReLU, stalling via en, and a per-frame end pulse.
module pool2x2_stream #(
    parameter int CH    = 12,
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter bit RELU  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             din_valid,
    input  logic [CH*DW-1:0] din,
    output logic [CH*DW-1:0] dout,
    output logic             dout_valid,
    output logic             pool_end,
    output logic             busy
);

    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int HW       = DW + 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    pool_mode_e         mode_q, mode_d;
    logic [CH*DW-1:0]   pair_q, pair_d;
    logic [CH*DW-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               pool_end_q, pool_end_d;

    logic [CH*HW-1:0]   lb_mem [LB_DEPTH];
    logic [CH*HW-1:0]   lb_rd;
    logic [LW-1:0]      lb_idx;
    logic               lb_we;

    logic               accept;
    logic               col_last;
    logic               row_last;
    logic [CH*DW-1:0]   relu_px;
    logic [CH*HW-1:0]   h_px;
    logic [CH*DW-1:0]   v_px;

    assign accept   = en && din_valid;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign lb_idx   = LW'(col_q >> 1);
    assign lb_rd    = lb_mem[lb_idx];

    // Per-lane datapath: ReLU, horizontal combine (DW+1 bits), vertical combine.
    // The first pixel of a frame sits at an even column, so combining never needs
    // the mode value being latched on that same cycle.
    always_comb begin
        logic signed [DW-1:0] x_s;
        logic signed [DW-1:0] p_s;
        logic signed [HW-1:0] h_s;
        logic signed [HW-1:0] l_s;
        logic signed [DW+1:0] s_s;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        x_s     = '0;
        p_s     = '0;
        h_s     = '0;
        l_s     = '0;
        s_s     = '0;
        relu_px = '0;
        h_px    = '0;
        v_px    = '0;
        for (int k = 0; k < CH; k++) begin
            x_s = din[k*DW +: DW];
            if (RELU && x_s[DW-1]) begin
                x_s = '0;
            end
            relu_px[k*DW +: DW] = x_s;

            p_s = pair_q[k*DW +: DW];
            if (mode_q == MODE_AVG) begin
                h_s = {x_s[DW-1], x_s} + {p_s[DW-1], p_s};
            end else begin
                h_s = (x_s > p_s) ? {x_s[DW-1], x_s} : {p_s[DW-1], p_s};
            end
            h_px[k*HW +: HW] = h_s;

            l_s = lb_rd[k*HW +: HW];
            if (mode_q == MODE_AVG) begin
                // Four DW-bit values sum into DW+2 bits; floor-divide by 4 is back in range.
                s_s = {l_s[HW-1], l_s} + {h_s[HW-1], h_s};
                v_px[k*DW +: DW] = DW'(s_s >>> 2);
            end else begin
                v_px[k*DW +: DW] = (h_s > l_s) ? DW'(h_s) : DW'(l_s);
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        pair_d       = pair_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        pool_end_d   = 1'b0;
        lb_we        = 1'b0;
        if (accept) begin
            if ((col_q == '0) && (row_q == '0)) begin
                mode_d = pool_mode_e'(mode);
            end

            if (!col_q[0]) begin
                pair_d = relu_px;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                dout_d       = v_px;
                dout_valid_d = 1'b1;
                pool_end_d   = row_last && col_last;
            end

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= MODE_MAX;
            pair_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            pool_end_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            pair_q       <= pair_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            pool_end_q   <= pool_end_d;
        end
    end

    // NOTE: the line buffer is written on every even row before being read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_mem[lb_idx] <= h_px;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign pool_end   = pool_end_q;
    assign busy       = (col_q != '0) || (row_q != '0);

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream on 4x4 frames: max/avg, ReLU, gaps, mode latch, reset, 12 lanes.
module tb_pool2x2_stream;

    typedef logic [7:0] px_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        din_valid;
    px_t         din_a;
    logic [95:0] din_w;
    px_t         dout_a, dout_r;
    logic [95:0] dout_w;
    logic        dv_a, pe_a, busy_a;
    logic        dv_r, pe_r, busy_r;
    logic        dv_w, pe_w, busy_w;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stray_end = 0;
    px_t         out_q[$];
    bit          end_q[$];
    px_t         relu_q[$];
    logic [95:0] wide_q[$];
    logic        obs_v, obs_e;
    px_t         obs_d;

    px_t ramp_f[16];
    px_t avg_f[16]  = '{8'hFF, 8'hFE, 8'h7F, 8'h7F,
                        8'hFD, 8'hFC, 8'h7F, 8'h7F,
                        8'h03, 8'h04, 8'h80, 8'h80,
                        8'h05, 8'h07, 8'h80, 8'h80};
    px_t relu_f[16] = '{8'hFB, 8'hF9, 8'h01, 8'hFE,
                        8'hFF, 8'hF7, 8'h03, 8'hFC,
                        8'h80, 8'h80, 8'h0A, 8'h14,
                        8'h80, 8'h80, 8'h1E, 8'h28};
    px_t exp_ramp[4]  = '{8'd5, 8'd7, 8'd13, 8'd15};
    px_t exp_avg[4]   = '{8'hFD, 8'h7F, 8'h04, 8'h80};
    px_t exp_relu0[4] = '{8'hFF, 8'h03, 8'h80, 8'h28};
    px_t exp_relu1[4] = '{8'h00, 8'h03, 8'h00, 8'h28};

    always #5 clk = ~clk;

    pool2x2_stream #(.CH(1), .DW(8), .IMG_W(4), .IMG_H(4), .RELU(1'b0)) u_max (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_valid(din_valid), .din(din_a),
        .dout(dout_a), .dout_valid(dv_a), .pool_end(pe_a), .busy(busy_a)
    );

    pool2x2_stream #(.CH(1), .DW(8), .IMG_W(4), .IMG_H(4), .RELU(1'b1)) u_relu (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_valid(din_valid), .din(din_a),
        .dout(dout_r), .dout_valid(dv_r), .pool_end(pe_r), .busy(busy_r)
    );

    pool2x2_stream #(.CH(12), .DW(8), .IMG_W(4), .IMG_H(4), .RELU(1'b0)) u_wide (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_valid(din_valid), .din(din_w),
        .dout(dout_w), .dout_valid(dv_w), .pool_end(pe_w), .busy(busy_w)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit after the rising edge.
    task automatic step(input logic e, input logic v, input px_t a, input logic [95:0] w);
        en        = e;
        din_valid = v;
        din_a     = a;
        din_w     = w;
        @(posedge clk);
        #1;
        obs_v = dv_a;
        obs_e = pe_a;
        obs_d = dout_a;
        if (dv_a) begin
            out_q.push_back(dout_a);
            end_q.push_back(pe_a);
        end
        if (pe_a && !dv_a) stray_end++;
        if (dv_r) relu_q.push_back(dout_r);
        if (dv_w) wide_q.push_back(dout_w);
        @(negedge clk);
    endtask

    task automatic send_frame(input px_t pix[16], input logic m, input bit gaps, input int toggle_at);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) mode = m;
            else if (i == toggle_at) mode = ~mode;
            if (gaps && (i % 3 != 0)) begin
                step(1'b0, 1'b1, 8'hAA, '0);
                step(1'b1, 1'b0, 8'h55, '0);
            end
            step(1'b1, 1'b1, pix[i], '0);
        end
    endtask

    task automatic expect_frame(input string tag, input px_t exp[4]);
        px_t got_d;
        bit  got_e;
        check({tag, "_count"}, 96'(out_q.size() >= 4), 96'(1));
        for (int j = 0; j < 4; j++) begin
            if (out_q.size() == 0) break;
            got_d = out_q.pop_front();
            got_e = end_q.pop_front();
            check({tag, "_dout"}, 96'(got_d), 96'(exp[j]));
            check({tag, "_end"}, 96'(got_e), 96'(j == 3));
        end
    endtask

    initial begin
        logic [95:0] w;
        logic [95:0] exp_w;
        int          bases[4] = '{5, 7, 13, 15};
        bit          exp_v;

        for (int i = 0; i < 16; i++) ramp_f[i] = px_t'(i);
        rst = 1'b1; en = 1'b0; mode = 1'b0; din_valid = 1'b0; din_a = '0; din_w = '0;
        @(negedge clk);
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        check("rst_dout", 96'(dout_a), 96'(0));
        check("rst_valid", 96'(dv_a), 96'(0));
        check("rst_end", 96'(pe_a), 96'(0));
        check("rst_busy", 96'(busy_a), 96'(0));
        check("rst_dout_w", dout_w, 96'(0));

        // Max ramp with exact output timing, chained straight into an avg frame.
        mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, px_t'(i), '0);
            exp_v = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            check("t1_valid", 96'(obs_v), 96'(exp_v));
            if (exp_v) begin
                check("t1_dout", 96'(obs_d), 96'(px_t'(i)));
                check("t1_end", 96'(obs_e), 96'(i == 15));
            end
            if (i == 0) check("t1_busy_mid", 96'(busy_a), 96'(1));
        end
        check("t1_busy_done", 96'(busy_a), 96'(0));
        out_q.delete();
        end_q.delete();
        send_frame(avg_f, 1'b1, 1'b0, -1);
        expect_frame("t2_avg", exp_avg);

        relu_q.delete();
        send_frame(relu_f, 1'b0, 1'b0, -1);
        expect_frame("t3_relu0", exp_relu0);
        check("t3_relu1_count", 96'(relu_q.size()), 96'(4));
        for (int j = 0; j < 4; j++) begin
            if (j < relu_q.size()) check("t3_relu1_dout", 96'(relu_q[j]), 96'(exp_relu1[j]));
        end

        // Same two frames with en/din_valid gaps, back-to-back.
        send_frame(ramp_f, 1'b0, 1'b1, -1);
        send_frame(avg_f, 1'b1, 1'b1, -1);
        expect_frame("t4_ramp", exp_ramp);
        expect_frame("t4_avg", exp_avg);
        check("t4_extra", 96'(out_q.size()), 96'(0));

        // Mode change mid-frame is ignored until the next frame.
        send_frame(ramp_f, 1'b0, 1'b0, 3);
        send_frame(avg_f, 1'b1, 1'b0, -1);
        expect_frame("t5_toggle_max", exp_ramp);
        expect_frame("t5_next_avg", exp_avg);

        // Reset in the middle of a frame, then a fresh frame.
        mode = 1'b0;
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, px_t'(i), '0);
        out_q.delete();
        end_q.delete();
        rst = 1'b1;
        step(1'b1, 1'b1, px_t'(11), '0);
        rst = 1'b0;
        check("t5_rst_busy", 96'(busy_a), 96'(0));
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        check("t5_rst_quiet", 96'(out_q.size()), 96'(0));
        send_frame(ramp_f, 1'b0, 1'b0, -1);
        expect_frame("t5_fresh", exp_ramp);
        check("t5_extra", 96'(out_q.size()), 96'(0));

        // 12 lanes, lane k = k + pixel index; lanes pool independently in order.
        rst = 1'b1;
        step(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        wide_q.delete();
        mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 12; k++) w[k*8 +: 8] = px_t'(k + i);
            step(1'b1, 1'b1, '0, w);
        end
        check("t6_count", 96'(wide_q.size()), 96'(4));
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 12; k++) exp_w[k*8 +: 8] = px_t'(k + bases[j]);
            if (j < wide_q.size()) check("t6_lanes", wide_q[j], exp_w);
        end

        check("stray_pool_end", 96'(stray_end), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
